// File: rtl/wpa2_mem_arbiter.sv
// Round-robin arbiter between the host Avalon path (r0) and the PBKDF2/SHA-1
// engine (r1) for the shared single-port on-chip RAM, with locked bursts.
module wpa2_mem_arbiter #(
    parameter int ADDR_W    = 13,
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 6370,
    parameter int MAX_BURST = 8
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  r0_req,
    input  logic                  r0_lock,
    input  logic                  r0_write,
    input  logic [ADDR_W-1:0]     r0_address,
    input  logic [DATA_W/8-1:0]   r0_byteenable,
    input  logic [DATA_W-1:0]     r0_writedata,
    output logic                  r0_gnt,
    output logic                  r0_rvalid,
    output logic [DATA_W-1:0]     r0_readdata,
    output logic                  r0_err,

    input  logic                  r1_req,
    input  logic                  r1_lock,
    input  logic                  r1_write,
    input  logic [ADDR_W-1:0]     r1_address,
    input  logic [DATA_W/8-1:0]   r1_byteenable,
    input  logic [DATA_W-1:0]     r1_writedata,
    output logic                  r1_gnt,
    output logic                  r1_rvalid,
    output logic [DATA_W-1:0]     r1_readdata,
    output logic                  r1_err,

    output logic [ADDR_W-1:0]     mem_address,
    output logic [DATA_W/8-1:0]   mem_byteenable,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic [DATA_W-1:0]     mem_writedata,
    output logic                  mem_clken,
    input  logic [DATA_W-1:0]     mem_readdata
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [ADDR_W:0]  DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] MAX_L   = CNT_W'(MAX_BURST);

    typedef enum logic [1:0] {
        IDLE,
        OWN0,
        OWN1
    } state_t;

    state_t           state;
    logic             last_gnt;
    logic [CNT_W-1:0] beat_cnt;

    logic             rsp_valid;
    logic             rsp_idx;
    logic             rsp_rd;
    logic             rsp_err;

    logic                g0;
    logic                g1;
    logic                grant;
    logic                sel;
    logic [ADDR_W-1:0]   w_addr;
    logic [DATA_W/8-1:0] w_be;
    logic [DATA_W-1:0]   w_wd;
    logic                w_write;
    logic                w_lock;
    logic                in_range;
    logic                other_req;
    logic                owned_by_win;
    logic [CNT_W-1:0]    base_cnt;
    logic [CNT_W-1:0]    new_cnt;
    logic                force_rel;

    // An owner that stops requesting forfeits the slot to normal arbitration.
    always_comb begin
        g0 = 1'b0;
        g1 = 1'b0;
        if (!reset) begin
            case (state)
                OWN0: begin
                    if (r0_req) g0 = 1'b1;
                    else        g1 = r1_req;
                end
                OWN1: begin
                    if (r1_req) g1 = 1'b1;
                    else        g0 = r0_req;
                end
                default: begin
                    if (r0_req && r1_req) begin
                        g0 = last_gnt;
                        g1 = ~last_gnt;
                    end else begin
                        g0 = r0_req;
                        g1 = r1_req;
                    end
                end
            endcase
        end
    end

    assign grant   = g0 | g1;
    assign sel     = g1;
    assign w_addr  = sel ? r1_address    : r0_address;
    assign w_be    = sel ? r1_byteenable : r0_byteenable;
    assign w_wd    = sel ? r1_writedata  : r0_writedata;
    assign w_write = sel ? r1_write      : r0_write;
    assign w_lock  = sel ? r1_lock       : r0_lock;

    assign other_req = sel ? r0_req : r1_req;
    assign in_range  = ({1'b0, w_addr} < DEPTH_L);

    assign mem_address    = grant ? w_addr : '0;
    assign mem_byteenable = grant ? w_be   : '0;
    assign mem_writedata  = grant ? w_wd   : '0;
    assign mem_chipselect = grant & in_range;
    assign mem_write      = grant & in_range & w_write;
    assign mem_clken      = 1'b1;

    // Burst length restarts whenever the winner is not the current owner.
    assign owned_by_win = ((state == OWN0) && !sel) ||
                          ((state == OWN1) &&  sel);
    assign base_cnt  = owned_by_win ? beat_cnt : '0;
    assign new_cnt   = (base_cnt >= MAX_L) ? MAX_L : base_cnt + 1'b1;
    assign force_rel = (new_cnt >= MAX_L) && other_req;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            last_gnt  <= 1'b1;
            beat_cnt  <= '0;
            rsp_valid <= 1'b0;
            rsp_idx   <= 1'b0;
            rsp_rd    <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= grant;
            rsp_idx   <= sel;
            rsp_rd    <= grant & in_range & ~w_write;
            rsp_err   <= grant & ~in_range;
            if (grant) begin
                last_gnt <= sel;
                if (w_lock && !force_rel) begin
                    state    <= sel ? OWN1 : OWN0;
                    beat_cnt <= new_cnt;
                end else begin
                    state    <= IDLE;
                    beat_cnt <= '0;
                end
            end else begin
                state    <= IDLE;
                beat_cnt <= '0;
            end
        end
    end

    assign r0_gnt = g0;
    assign r1_gnt = g1;

    // Responses are masked while reset is held so nothing in flight escapes.
    assign r0_rvalid   = rsp_valid & ~rsp_idx & ~reset;
    assign r1_rvalid   = rsp_valid &  rsp_idx & ~reset;
    assign r0_readdata = (r0_rvalid & rsp_rd) ? mem_readdata : '0;
    assign r1_readdata = (r1_rvalid & rsp_rd) ? mem_readdata : '0;
    assign r0_err      = r0_rvalid & rsp_err;
    assign r1_err      = r1_rvalid & rsp_err;

endmodule

// File: tb/tb_wpa2_mem_arbiter.sv
// Scoreboard bench for wpa2_mem_arbiter with a registered-address RAM model.
// Directed steps push expected responses; a negedge monitor pops and checks.
module tb_wpa2_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        r0_req, r0_lock, r0_write;
    logic [12:0] r0_address;
    logic [3:0]  r0_byteenable;
    logic [31:0] r0_writedata;
    logic        r0_gnt, r0_rvalid, r0_err;
    logic [31:0] r0_readdata;
    logic        r1_req, r1_lock, r1_write;
    logic [12:0] r1_address;
    logic [3:0]  r1_byteenable;
    logic [31:0] r1_writedata;
    logic        r1_gnt, r1_rvalid, r1_err;
    logic [31:0] r1_readdata;
    logic [12:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect, mem_write, mem_clken;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata = '0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct packed {
        logic [31:0] d;
        logic        e;
        int          cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    logic [31:0] ram [0:8191];

    always #5 clk = ~clk;

    wpa2_mem_arbiter dut (
        .clk(clk), .reset(reset),
        .r0_req(r0_req), .r0_lock(r0_lock), .r0_write(r0_write),
        .r0_address(r0_address), .r0_byteenable(r0_byteenable),
        .r0_writedata(r0_writedata), .r0_gnt(r0_gnt),
        .r0_rvalid(r0_rvalid), .r0_readdata(r0_readdata), .r0_err(r0_err),
        .r1_req(r1_req), .r1_lock(r1_lock), .r1_write(r1_write),
        .r1_address(r1_address), .r1_byteenable(r1_byteenable),
        .r1_writedata(r1_writedata), .r1_gnt(r1_gnt),
        .r1_rvalid(r1_rvalid), .r1_readdata(r1_readdata), .r1_err(r1_err),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_clken(mem_clken),
        .mem_readdata(mem_readdata)
    );

    function automatic logic [31:0] pat(input int i);
        return 32'h5A5A0000 | 32'(i);
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_clken && mem_chipselect) begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b])
                        ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
            end else begin
                mem_readdata <= ram[mem_address];
            end
        end
    end

    task automatic check_port(input int n, input logic rv,
                              input logic [31:0] rd, input logic er);
        exp_t e;
        logic due;
        due = 1'b0;
        e   = '0;
        if (n == 0) begin
            if (q0.size() > 0 && q0[0].cyc == cyc - 1) begin
                e = q0.pop_front();
                due = 1'b1;
            end
        end else begin
            if (q1.size() > 0 && q1[0].cyc == cyc - 1) begin
                e = q1.pop_front();
                due = 1'b1;
            end
        end
        if (reset) due = 1'b0;
        total++;
        if (rv !== due) begin
            bad++;
            $display("FAIL rvalid%0d cyc=%0d got=%b want=%b", n, cyc, rv, due);
        end
        if (due && rv) begin
            total++;
            if (rd !== e.d || er !== e.e) begin
                bad++;
                $display("FAIL rsp%0d cyc=%0d got=%h/%b want=%h/%b",
                         n, cyc, rd, er, e.d, e.e);
            end
        end
    endtask

    always @(negedge clk) begin
        check_port(0, r0_rvalid, r0_readdata, r0_err);
        check_port(1, r1_rvalid, r1_readdata, r1_err);
        if (reset) begin
            q0.delete();
            q1.delete();
        end
    end

    task automatic set0(input logic q, input logic l, input logic w,
                        input logic [12:0] a, input logic [3:0] be,
                        input logic [31:0] wd);
        r0_req = q; r0_lock = l; r0_write = w;
        r0_address = a; r0_byteenable = be; r0_writedata = wd;
    endtask

    task automatic set1(input logic q, input logic l, input logic w,
                        input logic [12:0] a, input logic [3:0] be,
                        input logic [31:0] wd);
        r1_req = q; r1_lock = l; r1_write = w;
        r1_address = a; r1_byteenable = be; r1_writedata = wd;
    endtask

    task automatic tick(input logic [1:0] g, input logic cs, input logic we,
                        input logic [31:0] d, input logic e, input string nm);
        exp_t x;
        @(negedge clk);
        total++;
        if ({r1_gnt, r0_gnt} !== g) begin
            bad++;
            $display("FAIL %s gnt cyc=%0d got=%b want=%b",
                     nm, cyc, {r1_gnt, r0_gnt}, g);
        end
        total++;
        if (mem_chipselect !== cs || mem_write !== we) begin
            bad++;
            $display("FAIL %s cs/we cyc=%0d got=%b%b want=%b%b",
                     nm, cyc, mem_chipselect, mem_write, cs, we);
        end
        x.d = d;
        x.e = e;
        x.cyc = cyc;
        if (g == 2'b01) q0.push_back(x);
        else if (g == 2'b10) q1.push_back(x);
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) ram[i] = pat(i);
        reset = 1'b1;
        set0(1'b1, 1'b0, 1'b0, 13'd0, 4'hF, 32'h0);
        set1(1'b1, 1'b0, 1'b0, 13'd1, 4'hF, 32'h0);
        for (int i = 0; i < 3; i++) tick(2'b00, 1'b0, 1'b0, 32'h0, 1'b0, "reset");
        reset = 1'b0;

        set0(1'b1, 1'b0, 1'b0, 13'd5, 4'hF, 32'h0);
        set1(1'b1, 1'b0, 1'b0, 13'd6, 4'hF, 32'h0);
        tick(2'b01, 1'b1, 1'b0, pat(5), 1'b0, "tie");
        tick(2'b10, 1'b1, 1'b0, pat(6), 1'b0, "rr1");
        tick(2'b01, 1'b1, 1'b0, pat(5), 1'b0, "rr2");
        tick(2'b10, 1'b1, 1'b0, pat(6), 1'b0, "rr3");

        set0(1'b0, 1'b0, 1'b0, 13'd0, 4'h0, 32'h0);
        set1(1'b1, 1'b0, 1'b1, 13'h0010, 4'b0101, 32'hDEADBEEF);
        tick(2'b10, 1'b1, 1'b1, 32'h0, 1'b0, "write");
        set1(1'b1, 1'b0, 1'b0, 13'h0010, 4'hF, 32'h0);
        tick(2'b10, 1'b1, 1'b0, 32'h5AAD00EF, 1'b0, "readback");

        set0(1'b1, 1'b1, 1'b0, 13'd32, 4'hF, 32'h0);
        set1(1'b1, 1'b0, 1'b0, 13'd33, 4'hF, 32'h0);
        for (int i = 0; i < 8; i++) tick(2'b01, 1'b1, 1'b0, pat(32), 1'b0, "burst");
        tick(2'b10, 1'b1, 1'b0, pat(33), 1'b0, "handover");
        set1(1'b0, 1'b0, 1'b0, 13'd0, 4'h0, 32'h0);
        for (int i = 0; i < 20; i++) tick(2'b01, 1'b1, 1'b0, pat(32), 1'b0, "long");
        set0(1'b0, 1'b0, 1'b0, 13'd0, 4'h0, 32'h0);
        tick(2'b00, 1'b0, 1'b0, 32'h0, 1'b0, "release");

        set0(1'b1, 1'b0, 1'b0, 13'd6369, 4'hF, 32'h0);
        tick(2'b01, 1'b1, 1'b0, 32'h5A5A18E1, 1'b0, "top");
        set0(1'b1, 1'b0, 1'b0, 13'd6370, 4'hF, 32'h0);
        tick(2'b01, 1'b0, 1'b0, 32'h0, 1'b1, "oor_rd");
        set0(1'b1, 1'b0, 1'b1, 13'd8191, 4'hF, 32'h12345678);
        tick(2'b01, 1'b0, 1'b0, 32'h0, 1'b1, "oor_wr");

        set0(1'b1, 1'b1, 1'b0, 13'd48, 4'hF, 32'h0);
        tick(2'b01, 1'b1, 1'b0, pat(48), 1'b0, "pre_rst");
        reset = 1'b1;
        set1(1'b1, 1'b0, 1'b0, 13'd49, 4'hF, 32'h0);
        tick(2'b00, 1'b0, 1'b0, 32'h0, 1'b0, "mid_rst");
        tick(2'b00, 1'b0, 1'b0, 32'h0, 1'b0, "mid_rst");
        reset = 1'b0;
        set0(1'b1, 1'b0, 1'b0, 13'd48, 4'hF, 32'h0);
        tick(2'b01, 1'b1, 1'b0, pat(48), 1'b0, "tie2");
        tick(2'b10, 1'b1, 1'b0, pat(49), 1'b0, "rr4");

        set0(1'b0, 1'b0, 1'b0, 13'd0, 4'h0, 32'h0);
        set1(1'b0, 1'b0, 1'b0, 13'd0, 4'h0, 32'h0);
        tick(2'b00, 1'b0, 1'b0, 32'h0, 1'b0, "drain");
        tick(2'b00, 1'b0, 1'b0, 32'h0, 1'b0, "drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
